// File: rtl/median_window_feeder_if.sv
// Pixel-pair input stream and 4x2 block output of the median window feeder.
// The master drives pixels in and consumes blocks; the slave is the feeder itself.
interface median_window_feeder_if #(
  parameter int PW = 8
);
  logic          in_valid;
  logic          in_sof;
  logic [2*PW-1:0] in_data;
  logic [PW-1:0] Q_00, Q_01, Q_02, Q_03;
  logic [PW-1:0] Q_10, Q_11, Q_12, Q_13;
  logic          out_valid;
  logic          out_first;
  logic          med_valid;

  modport master (
    output in_valid, in_sof, in_data,
    input  Q_00, Q_01, Q_02, Q_03, Q_10, Q_11, Q_12, Q_13,
    input  out_valid, out_first, med_valid
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output Q_00, Q_01, Q_02, Q_03, Q_10, Q_11, Q_12, Q_13,
    output out_valid, out_first, med_valid
  );
endinterface

// File: rtl/median_window_feeder.sv
// Buffers a two-pixel-per-clock raster stream in a ring of four line memories and
// emits a 4-row x 2-column block per clock for a parallel 3x3 median filter.
module median_window_feeder #(
  parameter int PW    = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  median_window_feeder_if.slave bus
);
  localparam int NP = IMG_W / 2;
  localparam int CW = (NP > 1) ? $clog2(NP) : 1;
  localparam int RW = $clog2(IMG_H);

  typedef logic [2*PW-1:0] pair_t;

  pair_t          line_mem [4][NP];
  logic [CW-1:0]  col, eff_col, nxt_col;
  logic [RW-1:0]  row, eff_row, nxt_row;
  logic [1:0]     ptr, eff_ptr, nxt_ptr;
  logic           emit;
  pair_t          rd_0, rd_1, rd_2;

  // NOTE: every signal assigned in always_comb gets a default at the top so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    eff_col = col;
    eff_row = row;
    eff_ptr = ptr;
    if (bus.in_valid && bus.in_sof) begin
      eff_col = '0;
      eff_row = '0;
      eff_ptr = '0;
    end

    emit = bus.in_valid && eff_row[0] && (eff_row >= RW'(3));

    // Ring slots ptr+1..ptr+3 hold rows row-3..row-1 (2-bit wraparound).
    rd_0 = line_mem[eff_ptr + 2'd1][eff_col];
    rd_1 = line_mem[eff_ptr + 2'd2][eff_col];
    rd_2 = line_mem[eff_ptr + 2'd3][eff_col];

    nxt_col = eff_col + 1'b1;
    nxt_row = eff_row;
    nxt_ptr = eff_ptr;
    if (eff_col == CW'(NP - 1)) begin
      nxt_col = '0;
      if (eff_row == RW'(IMG_H - 1)) begin
        nxt_row = '0;
        nxt_ptr = '0;
      end else begin
        nxt_row = eff_row + 1'b1;
        nxt_ptr = eff_ptr + 2'd1;
      end
    end
  end

  // NOTE: line memories carry no reset; they are always written before being read
  // within a frame, and a reset term would prevent mapping them onto RAM.
  always_ff @(posedge clk) begin
    if (bus.in_valid) line_mem[eff_ptr][eff_col] <= bus.in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col           <= '0;
      row           <= '0;
      ptr           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.med_valid <= 1'b0;
      bus.Q_00      <= '0;
      bus.Q_01      <= '0;
      bus.Q_02      <= '0;
      bus.Q_03      <= '0;
      bus.Q_10      <= '0;
      bus.Q_11      <= '0;
      bus.Q_12      <= '0;
      bus.Q_13      <= '0;
    end else begin
      if (bus.in_valid) begin
        col <= nxt_col;
        row <= nxt_row;
        ptr <= nxt_ptr;
      end
      // out_valid doubles as "emitted last cycle" for the med_valid chain.
      bus.out_valid <= emit;
      bus.out_first <= emit && (eff_col == '0);
      bus.med_valid <= emit && bus.out_valid && (eff_col != '0);
      if (emit) begin
        bus.Q_00 <= rd_0[PW-1:0];
        bus.Q_01 <= rd_1[PW-1:0];
        bus.Q_02 <= rd_2[PW-1:0];
        bus.Q_03 <= bus.in_data[PW-1:0];
        bus.Q_10 <= rd_0[2*PW-1:PW];
        bus.Q_11 <= rd_1[2*PW-1:PW];
        bus.Q_12 <= rd_2[2*PW-1:PW];
        bus.Q_13 <= bus.in_data[2*PW-1:PW];
      end
    end
  end
endmodule

// File: tb/tb_median_window_feeder.sv
// Randomized and ramp-frame bench for median_window_feeder against a frame-store
// reference model that recomputes each expected block from the image rows.
module tb_median_window_feeder;
  localparam int PW     = 8;
  localparam int W      = 8;
  localparam int H      = 8;
  localparam int NP     = W / 2;
  localparam int NPAIRS = NP * H;
  localparam int BLOCKS = (H / 2 - 1) * NP;
  localparam int MEDS   = (H / 2 - 1) * (NP - 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  median_window_feeder_if #(.PW(PW)) bus ();

  median_window_feeder #(.PW(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [63:0] q_obs;
  assign q_obs = {bus.Q_13, bus.Q_12, bus.Q_11, bus.Q_10,
                  bus.Q_03, bus.Q_02, bus.Q_01, bus.Q_00};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the frame as an image array plus a raster position.
  int          img [H][W];
  int          pos;
  bit          prev_emit;
  logic [63:0] exp_q;
  bit          exp_ov, exp_first, exp_med;
  int          blocks_seen, meds_seen;

  task automatic model_clock(input bit v, input bit s, input logic [15:0] d);
    int r, c;
    if (!rst) begin
      pos = 0; prev_emit = 0; exp_q = '0;
      exp_ov = 0; exp_first = 0; exp_med = 0;
      return;
    end
    exp_ov = 0; exp_first = 0; exp_med = 0;
    if (v) begin
      if (s) pos = 0;
      r = pos / NP;
      c = pos % NP;
      img[r][2*c]   = int'(d[7:0]);
      img[r][2*c+1] = int'(d[15:8]);
      if ((r % 2 == 1) && (r >= 3)) begin
        exp_ov    = 1;
        exp_first = (c == 0);
        exp_med   = prev_emit && (c != 0);
        for (int k = 0; k < 4; k++) begin
          exp_q[8*k +: 8]      = 8'(img[r-3+k][2*c]);
          exp_q[32+8*k +: 8]   = 8'(img[r-3+k][2*c+1]);
        end
      end
      pos = (pos + 1) % NPAIRS;
    end
    prev_emit = exp_ov;
  endtask

  task automatic step(input bit v, input bit s, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    @(posedge clk);
    model_clock(v, s, d);
    #1;
    check("q_block",   q_obs,         exp_q);
    check("out_valid", bus.out_valid, 64'(exp_ov));
    check("out_first", bus.out_first, 64'(exp_first));
    check("med_valid", bus.med_valid, 64'(exp_med));
    if (bus.out_valid) blocks_seen++;
    if (bus.med_valid) meds_seen++;
  endtask

  // Stream one frame; optional idle cycle before pair gap_at, optional stop before abort_at.
  task automatic feed_frame(input bit ramp, input int gap_at, input int abort_at);
    logic [15:0] d;
    int r, c;
    blocks_seen = 0;
    meds_seen   = 0;
    for (int k = 0; k < NPAIRS; k++) begin
      if (k == abort_at) return;
      if (k == gap_at) step(1'b0, 1'b0, 16'($urandom));
      r = k / NP;
      c = k % NP;
      d = ramp ? {8'(16*r + 2*c + 1), 8'(16*r + 2*c)} : 16'($urandom);
      step(1'b1, k == 0, d);
      if (ramp && gap_at < 0) begin
        if (k == 12) begin
          check("first_blk_q",     q_obs,         64'h3121_1101_3020_1000);
          check("first_blk_first", bus.out_first, 64'd1);
        end
        if (k == 13) begin
          check("second_blk_q00",   bus.Q_00,      64'd2);
          check("second_blk_first", bus.out_first, 64'd0);
          check("second_blk_med",   bus.med_valid, 64'd1);
        end
        if (k == 20) check("band_stride_q00", bus.Q_00, 64'd32);
      end
      if (gap_at >= 0 && k == gap_at) begin
        check("gap_out_valid", bus.out_valid, 64'd1);
        check("gap_med_valid", bus.med_valid, 64'd0);
      end
      if (gap_at >= 0 && k == gap_at + 1) check("after_gap_med", bus.med_valid, 64'd1);
    end
    step(1'b0, 1'b0, 16'h0);
    check("blocks_per_frame", 64'(blocks_seen), 64'(BLOCKS));
    check("meds_per_frame",   64'(meds_seen),   64'(MEDS - ((gap_at >= 0) ? 1 : 0)));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    rst          = 1'b0;

    // Reset held with in_valid high: outputs must stay at zero.
    repeat (3) step(1'b1, 1'b0, 16'($urandom));
    rst = 1'b1;

    feed_frame(1'b1, -1, -1);
    feed_frame(1'b0, -1, -1);
    feed_frame(1'b0, -1, -1);

    // Idle cycle before row 3, column pair 2.
    feed_frame(1'b1, 14, -1);

    // New sof arrives at row 4, column pair 2.
    feed_frame(1'b1, -1, 18);
    feed_frame(1'b0, -1, -1);

    // Asynchronous reset between clocks during row 5.
    feed_frame(1'b1, -1, 22);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_q",     q_obs,         64'd0);
    check("async_rst_valid", bus.out_valid, 64'd0);
    check("async_rst_first", bus.out_first, 64'd0);
    check("async_rst_med",   bus.med_valid, 64'd0);
    model_clock(1'b0, 1'b0, 16'h0);
    repeat (2) step(1'b0, 1'b0, 16'h0);
    rst = 1'b1;
    feed_frame(1'b1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
